// File: rtl/axi4_slave_write_responder.sv
// rtl/axi4_slave_write_responder.sv - AXI4 slave write channel responder with internal storage
//
// Accepts one AXI4 write burst at a time (AW -> W beats -> B), writes the beats
// into an internal word array with byte-lane strobes, and returns OKAY or SLVERR.
// Optional feature macro: AXI4_SLV_WRAP_BURST_EN (enables WRAP bursts; without it
// WRAP is handled like the reserved burst type).
//
// Ports:
//   aclk, areset            clock, synchronous active-high reset
//   aw*                     write address channel (awready high only when idle)
//   w*                      write data channel (wready high only while collecting beats)
//   b*                      write response channel (held until bready)
//   dbg_addr / dbg_rdata    combinational word read of the storage array
module axi4_slave_write_responder #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_DEPTH     = 256
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [3:0]                   awid,
  input  logic [ADDRESS_WIDTH-1:0]     awaddr,
  input  logic [7:0]                   awlen,
  input  logic [2:0]                   awsize,
  input  logic [1:0]                   awburst,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [DATA_WIDTH/8-1:0]      wstrb,
  input  logic                         wlast,
  input  logic                         wvalid,
  output logic                         wready,
  output logic [3:0]                   bid,
  output logic [1:0]                   bresp,
  output logic                         bvalid,
  input  logic                         bready,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]        dbg_rdata
);

  localparam int NBYTES  = DATA_WIDTH / 8;
  localparam int LANE_SH = $clog2(NBYTES);
  localparam int IDXW    = $clog2(MEM_DEPTH);
  localparam int AW1     = ADDRESS_WIDTH + 1;
  localparam logic [AW1-1:0] MEM_BYTES = AW1'(MEM_DEPTH * NBYTES);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t                   state_q, state_d;
  logic [3:0]               id_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [7:0]               len_q;
  logic [2:0]               size_q;
  logic [1:0]               burst_q;
  logic [7:0]               beat_q;
  logic                     err_q;
  logic                     supp_q;

  logic [DATA_WIDTH-1:0]    mem [MEM_DEPTH];

  logic                     aw_hs, w_hs, beat_is_last, burst_end, aw_bad, oob, do_write;
  logic [ADDRESS_WIDTH-1:0] step, addr_inc, addr_nxt;
  logic [IDXW-1:0]          word_idx;

  // Burst-level faults decided once at AW time; they poison the whole burst.
  always_comb begin
    aw_bad = (awsize > 3'(LANE_SH)) || (awburst == 2'b11);
`ifdef AXI4_SLV_WRAP_BURST_EN
    if (awburst == BURST_WRAP && !(awlen inside {8'd1, 8'd3, 8'd7, 8'd15}))
      aw_bad = 1'b1;
`else
    if (awburst == BURST_WRAP)
      aw_bad = 1'b1;
`endif
  end

  // Address of the next beat, derived from the current beat address.
  always_comb begin
    step     = ADDRESS_WIDTH'(1) << size_q;
    addr_inc = addr_q + step;
    addr_nxt = addr_inc;
    if (burst_q == BURST_FIXED) begin
      addr_nxt = addr_q;
    end else if (burst_q == BURST_INCR) begin
      addr_nxt = addr_inc;
    end
`ifdef AXI4_SLV_WRAP_BURST_EN
    else if (burst_q == BURST_WRAP) begin : wrap_calc
      logic [ADDRESS_WIDTH-1:0] cont, base;
      cont = (ADDRESS_WIDTH'(len_q) + ADDRESS_WIDTH'(1)) << size_q;
      base = addr_q & ~(cont - ADDRESS_WIDTH'(1));
      addr_nxt = (addr_inc == base + cont) ? base : addr_inc;
    end
`endif
  end

  assign oob      = ({1'b0, addr_q} >= MEM_BYTES);
  assign word_idx = IDXW'(addr_q >> LANE_SH);

  // FSM next state and handshake outputs; areset gates the ready/valid
  // outputs so they read 0 for the whole reset window.
  always_comb begin
    state_d      = state_q;
    awready      = 1'b0;
    wready       = 1'b0;
    bvalid       = 1'b0;
    bid          = 4'd0;
    bresp        = 2'b00;
    aw_hs        = 1'b0;
    w_hs         = 1'b0;
    beat_is_last = (beat_q == len_q);
    burst_end    = 1'b0;
    if (!areset) begin
      case (state_q)
        IDLE: begin
          awready = 1'b1;
          aw_hs   = awvalid;
          if (aw_hs) state_d = DATA;
        end
        DATA: begin
          wready    = 1'b1;
          w_hs      = wvalid;
          burst_end = w_hs && (wlast || beat_is_last);
          if (burst_end) state_d = RESP;
        end
        RESP: begin
          bvalid = 1'b1;
          bid    = id_q;
          bresp  = err_q ? 2'b10 : 2'b00;
          if (bready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign do_write = w_hs && !supp_q && !oob;

  always_ff @(posedge aclk) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      id_q   <= 4'd0;
      beat_q <= 8'd0;
      err_q  <= 1'b0;
      supp_q <= 1'b0;
    end else if (aw_hs) begin
      id_q    <= awid;
      addr_q  <= awaddr;
      len_q   <= awlen;
      size_q  <= awsize;
      burst_q <= awburst;
      beat_q  <= 8'd0;
      err_q   <= aw_bad;
      supp_q  <= aw_bad;
    end else if (w_hs) begin
      addr_q <= addr_nxt;
      beat_q <= beat_q + 8'd1;
      if (oob || (wlast != beat_is_last)) err_q <= 1'b1;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge aclk) begin
    if (do_write) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (wstrb[b]) mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign dbg_rdata = mem[dbg_addr];

endmodule

// File: doc/axi4_slave_write_responder.md
AXI4_SLAVE_WRITE_RESPONDER -- requirements
Module: axi4_slave_write_responder

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, meaning awaddr width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning wdata width; legal values are 32 and 64.
REQ-003 SHALL have parameter MEM_DEPTH, default 256, meaning the number of DATA_WIDTH-bit words in internal storage.
REQ-004 SHALL use one clock and a synchronous active-high reset: aclk  input  1  rising-edge clock; areset  input  1  synchronous active-high reset.
REQ-005 SHALL have these AW ports: awid in 4; awaddr in ADDRESS_WIDTH; awlen in 8; awsize in 3; awburst in 2; awvalid in 1; awready out 1.
REQ-006 SHALL have these W ports: wdata in DATA_WIDTH; wstrb in DATA_WIDTH/8; wlast in 1; wvalid in 1; wready out 1.
REQ-007 SHALL have these B ports: bid out 4; bresp out 2; bvalid out 1; bready in 1.
REQ-008 SHALL have a debug port: dbg_addr in $clog2(MEM_DEPTH) (word index); dbg_rdata out DATA_WIDTH (combinational read of storage).

Function
REQ-009 SHALL implement FSM IDLE -> DATA -> RESP -> IDLE, serving one burst at a time.
REQ-010 SHALL assert awready only in IDLE; SHALL NOT assert wready or bvalid in IDLE.
REQ-011 SHALL latch awid/awaddr/awlen/awsize/awburst on the AW handshake in cycle N; SHALL enter DATA and assert wready in cycle N+1.
REQ-012 SHALL write storage on each W handshake for byte lanes where wstrb=1 and leave the other lanes unchanged.
REQ-013 SHALL use word index = beat address >> log2(DATA_WIDTH/8); a beat with byte address >= MEM_DEPTH*DATA_WIDTH/8 SHALL NOT write storage and SHALL set the error flag.
REQ-014 SHALL compute the beat address as follows: FIXED (00) keeps the start address; INCR (01) adds 1<<awsize per beat; WRAP (10) follows REQ-027/028; reserved (11) sets the error flag and suppresses all writes.
REQ-015 SHALL set the error flag and suppress all writes of the burst when awsize > log2(DATA_WIDTH/8).
REQ-016 SHALL count beats 0..awlen; the burst ends on the first W handshake that either carries wlast=1 or is beat awlen.
REQ-017 SHALL set the error flag when the wlast value disagrees with whether the beat is final (early wlast, or missing wlast on beat awlen).
REQ-018 SHALL, on the final W handshake in cycle M, deassert wready in cycle M+1 and assert bvalid in cycle M+1.
REQ-019 SHALL drive bid=latched awid, and bresp=2'b10 (SLVERR) if the error flag is set, else 2'b00 (OKAY).
REQ-020 SHALL hold bvalid, bid and bresp stable until bready=1.
REQ-021 SHALL, on the B handshake in cycle K, enter IDLE and assert awready in cycle K+1; bready=1 on bvalid's first cycle is legal.
REQ-022 SHALL clear the error flag on every AW handshake.
REQ-023 SHALL ignore wvalid while in IDLE or RESP, so W beats that arrive before AW stall.

Reset
REQ-024 SHALL, while areset=1, force state=IDLE, awready=0, wready=0, bvalid=0, bid=0, bresp=0, beat counter=0, error flag=0; awready=1 in the first cycle after release.
REQ-025 SHALL, on reset mid-burst, abort with no B response; words already written stay written.
REQ-026 SHALL NOT reset storage contents.

Configuration
REQ-027 With macro AXI4_SLV_WRAP_BURST_EN defined, WRAP SHALL be supported: awlen must be 1, 3, 7 or 15 (otherwise error flag set and writes suppressed); container=(awlen+1)<<awsize; the address increments by 1<<awsize and wraps to the container-aligned base on reaching base+container.
REQ-028 Without AXI4_SLV_WRAP_BURST_EN, awburst=WRAP SHALL be treated as reserved (writes suppressed, bresp=SLVERR), while all beats are still accepted until burst end.

Verification
REQ-029 After reset: single INCR, awaddr=0x10, awlen=0, awsize=2, wdata=0xDEADBEEF, wstrb=0xF, wlast=1 -> bvalid one cycle after the W handshake, bresp=00, bid=awid, dbg_addr=4 reads 0xDEADBEEF.
REQ-030 INCR awaddr=0x0, awlen=3, wstrb=0x3 on beat 2, with bready held 0 for 5 cycles -> words 0..3 written, word 2 upper 16 bits unchanged, B stable for 5 cycles, awready high the cycle after the B handshake.
REQ-031 wlast=1 on beat 1 of awlen=3 -> B after beat 1, bresp=10, beats 0..1 written; next burst with awid=5 returns OKAY, bid=5.
REQ-032 awaddr=MEM_DEPTH*4, awlen=0 -> bresp=10, no storage change; awburst=11 or awsize=3 with DATA_WIDTH=32 -> bresp=10, no writes.
REQ-033 With the macro: WRAP awaddr=0x38, awlen=3, awsize=2 -> words 14,15,12,13 written, bresp=00; without the macro, same stimulus -> bresp=10, no writes.
REQ-034 areset=1 during beat 2 of awlen=7 -> no bvalid; awready=1 one cycle after release; beats 0..1 remain in storage.
